// File: rtl/controle_player_pkg.sv
// Shared state encoding and track-index wrap helpers for the player controller.
package controle_player_pkg;

  localparam int unsigned ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } estado_t;

  // Out-of-range indices fold back into 0..n-1 so the selector can never stick outside it.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned n);
    return (v == 0 || v >= n) ? n - 1 : v - 1;
  endfunction

endpackage

// File: rtl/gera_pulso.sv
// Rising-edge detector: two flops, one-cycle pulse on a low-to-high input transition.
module gera_pulso (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pulso
);

  logic q1_q, q2_q;
  logic q1_d, q2_d;

  always_comb begin
    q1_d = button;
    q2_d = q1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q <= 1'b0;
      q2_q <= 1'b0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign pulso = q1_q & ~q2_q;

endmodule

// File: rtl/controle_player.sv
// Player control FSM (STOP/PLAY/PAUSE) with track selection and post-reset holdoff.
// Define CONTROLE_AUTO_AVANCO_EN to make end-of-track advance to the next track instead of stopping.
module controle_player
  import controle_player_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int N_FAIXAS = 4,
  parameter int HOLDOFF  = 255,
  localparam int SEL_W   = (N_FAIXAS > 1) ? $clog2(N_FAIXAS) : 1
) (
  input  logic             clk_placa,
  input  logic             rst,
  input  logic [N_SRC-1:0] stop_in,
  input  logic [N_SRC-1:0] play_in,
  input  logic [N_SRC-1:0] next_in,
  input  logic [N_SRC-1:0] prev_in,
  input  logic             fim_faixa,
  output logic             stop_out,
  output logic             play_out,
  output logic [SEL_W-1:0] sel_out,
  output logic [1:0]       estado_out,
  output logic             troca_out,
  output logic             pronto
);

  localparam int N_DET = 4 * N_SRC + 1;
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  logic [N_DET-1:0] raw, pulso;
  logic stop_p, play_p, next_p, prev_p, fim_p;

  assign raw = {fim_faixa, prev_in, next_in, play_in, stop_in};

  for (genvar gi = 0; gi < N_DET; gi++) begin : g_det
    gera_pulso u_det (
      .clk    (clk_placa),
      .rst    (rst),
      .button (raw[gi]),
      .pulso  (pulso[gi])
    );
  end

  assign stop_p = |pulso[0       +: N_SRC];
  assign play_p = |pulso[N_SRC   +: N_SRC];
  assign next_p = |pulso[2*N_SRC +: N_SRC];
  assign prev_p = |pulso[3*N_SRC +: N_SRC];
  assign fim_p  = pulso[4*N_SRC];

  estado_t          estado_q, estado_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             troca_q, troca_d;
  logic             stop_q, stop_d;
  logic             play_q, play_d;
  logic [HO_W-1:0]  cnt_q, cnt_d;
  logic             pronto_q, pronto_d;
  logic [SEL_W-1:0] sel_inc, sel_dec;

  assign sel_inc = SEL_W'(wrap_inc(32'(sel_q), N_FAIXAS));
  assign sel_dec = SEL_W'(wrap_dec(32'(sel_q), N_FAIXAS));

  always_comb begin
    cnt_d    = (cnt_q == HO_W'(HOLDOFF)) ? cnt_q : cnt_q + 1'b1;
    pronto_d = (cnt_d == HO_W'(HOLDOFF));
    estado_d = estado_q;
    sel_d    = sel_q;
    troca_d  = 1'b0;

    // Only the highest-priority pending command acts; lower ones are dropped for this cycle.
    if (pronto_q) begin
      if (stop_p) begin
        estado_d = ST_STOP;
      end else if (play_p) begin
        case (estado_q)
          ST_STOP:  estado_d = ST_PLAY;
          ST_PLAY:  estado_d = ST_PAUSE;
          ST_PAUSE: estado_d = ST_PLAY;
          default:  estado_d = ST_STOP;
        endcase
      end else if (next_p | prev_p) begin
        if (next_p ^ prev_p) begin
          sel_d   = next_p ? sel_inc : sel_dec;
          troca_d = 1'b1;
        end
      end else if (fim_p && estado_q == ST_PLAY) begin
`ifdef CONTROLE_AUTO_AVANCO_EN
        sel_d   = sel_inc;
        troca_d = 1'b1;
`else
        estado_d = ST_STOP;
`endif
      end
    end

    case (estado_q)
      ST_STOP, ST_PLAY, ST_PAUSE: ;
      default: estado_d = ST_STOP;
    endcase

    stop_d = (estado_d == ST_STOP);
    play_d = (estado_d == ST_PLAY);
  end

  always_ff @(posedge clk_placa) begin
    if (rst) begin
      estado_q <= ST_STOP;
      sel_q    <= '0;
      troca_q  <= 1'b0;
      stop_q   <= 1'b1;
      play_q   <= 1'b0;
      cnt_q    <= '0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      troca_q  <= troca_d;
      stop_q   <= stop_d;
      play_q   <= play_d;
      cnt_q    <= cnt_d;
      pronto_q <= pronto_d;
    end
  end

  assign stop_out   = stop_q;
  assign play_out   = play_q;
  assign sel_out    = sel_q;
  assign estado_out = estado_q;
  assign troca_out  = troca_q;
  assign pronto     = pronto_q;

endmodule

// File: tb/tb_controle_player.sv
// Directed bench for controle_player (N_SRC=2, N_FAIXAS=5, HOLDOFF=4), either build of CONTROLE_AUTO_AVANCO_EN.
module tb_controle_player;

  localparam int N_SRC    = 2;
  localparam int N_FAIXAS = 5;
  localparam int HOLDOFF  = 4;

  logic       clk_placa = 1'b0;
  logic       rst       = 1'b1;
  logic [1:0] stop_in   = '0;
  logic [1:0] play_in   = '0;
  logic [1:0] next_in   = '0;
  logic [1:0] prev_in   = '0;
  logic       fim_faixa = 1'b0;
  logic       stop_out, play_out, troca_out, pronto;
  logic [2:0] sel_out;
  logic [1:0] estado_out;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk_placa = ~clk_placa;

  controle_player #(
    .N_SRC    (N_SRC),
    .N_FAIXAS (N_FAIXAS),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk_placa  (clk_placa),
    .rst        (rst),
    .stop_in    (stop_in),
    .play_in    (play_in),
    .next_in    (next_in),
    .prev_in    (prev_in),
    .fim_faixa  (fim_faixa),
    .stop_out   (stop_out),
    .play_out   (play_out),
    .sel_out    (sel_out),
    .estado_out (estado_out),
    .troca_out  (troca_out),
    .pronto     (pronto)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_placa);
    #1;
  endtask

  // Raise the given bits for one cycle, then wait the edge where the outputs react.
  task automatic pulse_cmd(input logic [1:0] s, input logic [1:0] p, input logic [1:0] n,
                           input logic [1:0] pv, input logic f);
    stop_in = s; play_in = p; next_in = n; prev_in = pv; fim_faixa = f;
    tick();
    stop_in = '0; play_in = '0; next_in = '0; prev_in = '0; fim_faixa = 1'b0;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_estado", estado_out, 2'b00);
    chk("rst_stop",   stop_out,   1'b1);
    chk("rst_play",   play_out,   1'b0);
    chk("rst_sel",    sel_out,    3'd0);
    chk("rst_troca",  troca_out,  1'b0);
    chk("rst_pronto", pronto,     1'b0);

    // Command during holdoff is discarded.
    rst = 1'b0;
    tick();
    play_in = 2'b01;
    tick();
    play_in = 2'b00;
    tick();
    chk("hold_estado", estado_out, 2'b00);
    chk("hold_pronto", pronto,     1'b0);
    chk("hold_stop",   stop_out,   1'b1);
    tick();
    chk("pronto_up", pronto, 1'b1);

    pulse_cmd(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    chk("play_estado", estado_out, 2'b01);
    chk("play_play",   play_out,   1'b1);
    chk("play_stop",   stop_out,   1'b0);
    pulse_cmd(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    chk("pause_estado", estado_out, 2'b10);
    chk("pause_play",   play_out,   1'b0);
    chk("pause_stop",   stop_out,   1'b0);
    pulse_cmd(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("stop_estado", estado_out, 2'b00);
    chk("stop_stop",   stop_out,   1'b1);

    for (int i = 0; i < 5; i++) begin
      pulse_cmd(2'b00, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b0);
      chk("next_sel",   sel_out,   32'((i + 1) % 5));
      chk("next_troca", troca_out, 1'b1);
    end
    tick();
    chk("troca_fall", troca_out, 1'b0);
    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    chk("prev_wrap_sel",   sel_out,   3'd4);
    chk("prev_wrap_troca", troca_out, 1'b1);

    pulse_cmd(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    chk("play2_estado", estado_out, 2'b01);
    pulse_cmd(2'b01, 2'b10, 2'b00, 2'b00, 1'b0);
    chk("prio_estado", estado_out, 2'b00);
    chk("prio_stop",   stop_out,   1'b1);
    pulse_cmd(2'b00, 2'b00, 2'b01, 2'b10, 1'b0);
    chk("cancel_sel",   sel_out,   3'd4);
    chk("cancel_troca", troca_out, 1'b0);

    // A held button yields a single step.
    next_in = 2'b01;
    repeat (4) tick();
    next_in = 2'b00;
    tick();
    chk("held_sel",   sel_out,   3'd0);
    chk("held_troca", troca_out, 1'b0);

    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("fim_stop_estado", estado_out, 2'b00);
    chk("fim_stop_sel",    sel_out,    3'd0);

    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b10, 1'b0);
    pulse_cmd(2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    chk("pre_fim_estado", estado_out, 2'b01);
    chk("pre_fim_sel",    sel_out,    3'd4);
    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
`ifdef CONTROLE_AUTO_AVANCO_EN
    chk("fim_play_estado", estado_out, 2'b01);
    chk("fim_play_sel",    sel_out,    3'd0);
    chk("fim_play_troca",  troca_out,  1'b1);
    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    pulse_cmd(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
`else
    chk("fim_play_estado", estado_out, 2'b00);
    chk("fim_play_sel",    sel_out,    3'd4);
    chk("fim_play_troca",  troca_out,  1'b0);
    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    pulse_cmd(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
    pulse_cmd(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
`endif
    chk("pause3_estado", estado_out, 2'b10);
    chk("pause3_sel",    sel_out,    3'd3);

    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("fim_pause_estado", estado_out, 2'b10);
    chk("fim_pause_sel",    sel_out,    3'd3);
    pulse_cmd(2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    chk("next_pause_estado", estado_out, 2'b10);
    chk("next_pause_sel",    sel_out,    3'd4);
    pulse_cmd(2'b00, 2'b00, 2'b00, 2'b10, 1'b0);
    chk("prev_pause_sel", sel_out, 3'd3);

    // Reset in PAUSE, then a pulse landing on the cycle pronto rises.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_estado", estado_out, 2'b00);
    chk("rst2_sel",    sel_out,    3'd0);
    chk("rst2_pronto", pronto,     1'b0);
    chk("rst2_stop",   stop_out,   1'b1);
    repeat (3) tick();
    chk("rst2_hold_pronto", pronto, 1'b0);
    play_in = 2'b10;
    tick();
    play_in = 2'b00;
    chk("rst2_pronto_up", pronto,     1'b1);
    chk("rst2_pre_estado", estado_out, 2'b00);
    tick();
    chk("edge_accept_estado", estado_out, 2'b01);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/controle_player.md
CONTROLE_PLAYER -- requirements
Module: controle_player

Interface
REQ-001 The block SHALL have parameter N_SRC, default 2, meaning the number of command sources (board buttons, IR receiver, ...).
REQ-002 The block SHALL have parameter N_FAIXAS, default 4, meaning the number of selectable tracks (2..256, not necessarily a power of two).
REQ-003 The block SHALL have parameter HOLDOFF, default 255, meaning the number of post-reset cycles during which commands are ignored (minimum 1).
REQ-004 The block SHALL have derived localparam SEL_W = max(1, clog2(N_FAIXAS)).
REQ-005 The block SHALL have port clk_placa, input, 1, the single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1, with reset synchronous and active-high.
REQ-007 The block SHALL have ports stop_in, play_in, next_in and prev_in, each input, N_SRC, one command bit per source, level-active and asynchronous to clk_placa.
REQ-008 The block SHALL have port fim_faixa, input, 1, the end-of-track level from the audio path.
REQ-009 The block SHALL have ports stop_out and play_out, each output, 1: stop_out=1 in STOP, play_out=1 in PLAY, both 0 in PAUSE.
REQ-010 The block SHALL have ports sel_out, output, SEL_W, the current track index, and estado_out, output, 2, the state code.
REQ-011 The block SHALL have port troca_out, output, 1, a one-cycle pulse whenever sel_out changes, and port pronto, output, 1, which is high once holdoff has expired.

Function
REQ-012 Every command input bit and fim_faixa SHALL pass through its own rising-edge detector (two flops, pulse = q1 & ~q2).
REQ-013 Detector pulses of the same command SHALL be ORed across sources.
REQ-014 An input sampled high at edge N SHALL update the registered outputs at edge N+1.
REQ-015 A held input SHALL produce exactly one command.
REQ-016 The states SHALL be STOP=2'b00, PLAY=2'b01 and PAUSE=2'b10, with code 2'b11 recovering to STOP on the next edge.
REQ-017 In STOP, play SHALL move to PLAY.
REQ-018 In PLAY, stop SHALL move to STOP and play SHALL move to PAUSE.
REQ-019 In PAUSE, stop SHALL move to STOP and play SHALL move to PLAY.
REQ-020 Simultaneous command pulses SHALL resolve by priority stop > play > next/prev > fim_faixa, with only the highest-priority command acting in a cycle.
REQ-021 next and prev SHALL be accepted in all three states and SHALL leave the state unchanged.
REQ-022 next SHALL increment sel_out, wrapping from N_FAIXAS-1 to 0.
REQ-023 prev SHALL decrement sel_out, wrapping from 0 to N_FAIXAS-1.
REQ-024 next and prev in the same cycle SHALL cancel, leaving sel_out unchanged and troca_out low.
REQ-025 sel_out SHALL never hold a value >= N_FAIXAS.
REQ-026 troca_out SHALL be registered and SHALL assert in the same cycle sel_out takes its new value.
REQ-027 fim_faixa SHALL act only in PLAY and SHALL be ignored in STOP and PAUSE.
REQ-028 A holdoff counter SHALL count 0..HOLDOFF after reset, then saturate.
REQ-029 While the holdoff counter is below HOLDOFF, all pulses SHALL be discarded, outputs SHALL hold their reset values and pronto SHALL be 0.
REQ-030 A pulse arriving in the cycle pronto rises SHALL be accepted.

Reset
REQ-031 rst SHALL have priority over every other event at any edge, including mid-command and mid-holdoff.
REQ-032 Reset values SHALL be: estado STOP, stop_out=1, play_out=0, sel_out=0, troca_out=0, pronto=0, holdoff counter 0, edge-detector flops 0.
REQ-033 After reset, the holdoff count SHALL restart.
REQ-034 An input already high when rst deasserts SHALL generate one pulse, which holdoff discards.

Configuration
REQ-035 With macro CONTROLE_AUTO_AVANCO_EN defined, fim_faixa in PLAY SHALL advance sel_out as next does (including wrap), remain in PLAY and pulse troca_out.
REQ-036 Without CONTROLE_AUTO_AVANCO_EN, fim_faixa in PLAY SHALL move to STOP with sel_out unchanged and troca_out low.
REQ-037 The fim_faixa port SHALL exist in both builds.

Structure
REQ-038 A shared package SHALL hold the state codes STOP/PLAY/PAUSE and the state type width (2).
REQ-039 The edge detector SHALL be the existing sub-module gera_pulso (ports clk, button, pulso), instantiated through generate loops 4*N_SRC+1 times.
REQ-040 gera_pulso SHALL gain an rst input clearing its flops.

Verification (N_SRC=2, N_FAIXAS=5, HOLDOFF=4)
REQ-041 Reset, then play_in=2'b01 at cycle 2 -> ignored, pronto=0, stop_out=1, state STOP.
REQ-042 After pronto, play_in[1] pulse -> PLAY one edge later; second play_in[0] pulse -> PAUSE; stop_in[1] -> STOP, stop_out=1.
REQ-043 In STOP, 5 next pulses -> sel_out 1,2,3,4,0 with one troca_out each; one prev from 0 -> 4.
REQ-044 Same-cycle stop_in[0] and play_in[1] in PLAY -> STOP; same-cycle next and prev -> sel_out unchanged, troca_out=0.
REQ-045 PLAY with sel_out=4, fim_faixa rises -> with CONTROLE_AUTO_AVANCO_EN: sel_out=0, PLAY, troca_out pulse; without: STOP, sel_out=4.
REQ-046 rst asserted one cycle while in PAUSE with sel_out=3 -> next edge STOP, sel_out=0, pronto=0; pronto returns after 4 cycles.
